tick_event_timer: RTL

//  Downstream stage of the 4-bit prescaler counter: consumes its terminal-count output as tick_in.

---
 rtl/tick_event_timer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/tick_event_timer.sv
`default_nettype none
// ============================================================================
// Module   : tick_event_timer
// Brief    : Counts prescaled ticks down from a programmable load value and
//            flags expiry; supports one-shot and periodic auto-reload.
// Revision : 1.0 - initial release
// ============================================================================
module tick_event_timer #(
    parameter int WIDTH     = 8,
    parameter int TICK_EDGE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick_in,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_periodic,
    input  logic [WIDTH-1:0] load_value,
    input  logic             flag_clear,
    output logic [WIDTH-1:0] count_out,
    output logic             expire_pulse,
    output logic             expired_flag,
    output logic             overrun_flag,
    output logic             start_err,
    output logic             busy,
    output logic [1:0]       state_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    state_t           state_q,        state_d;
    logic [WIDTH-1:0] count_q,        count_d;
    logic [WIDTH-1:0] reload_q,       reload_d;
    logic             periodic_q,     periodic_d;
    logic             tick_prev_q,    tick_prev_d;
    logic             expire_pulse_q, expire_pulse_d;
    logic             expired_flag_q, expired_flag_d;
    logic             overrun_flag_q, overrun_flag_d;
    logic             start_err_q,    start_err_d;
    logic             tick_rise;
    logic             expire;

    // Level mode forces the history term high so every high cycle counts.
    assign tick_rise   = tick_in & (~tick_prev_q | (TICK_EDGE == 0));
    assign tick_prev_d = tick_in;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        reload_d   = reload_q;
        periodic_d = periodic_q;
        start_err_d = 1'b0;
        expire      = 1'b0;

        if (stop) begin
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        end else if (start) begin
            // A rejected start still consumes the cycle, so a coincident tick is dropped.
            if (load_value != '0) begin
                state_d    = ST_RUN;
                count_d    = load_value;
                reload_d   = load_value;
                periodic_d = mode_periodic;
            end else begin
                start_err_d = 1'b1;
            end
        end else if ((state_q == ST_RUN) && tick_rise) begin
            if (count_q > c_one) begin
                count_d = count_q - c_one;
            end else if (count_q == c_one) begin
                expire = 1'b1;
                if (periodic_q) begin
                    count_d = reload_q;
                end else begin
                    count_d = '0;
                    state_d = ST_DONE;
                end
            end
        end

        // Expiry wins over a simultaneous clear; overrun looks at the pre-clear flag.
        expire_pulse_d = expire;
        expired_flag_d = expire | (expired_flag_q & ~flag_clear);
        overrun_flag_d = (expire & expired_flag_q) | (overrun_flag_q & ~flag_clear);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            reload_q       <= '0;
            periodic_q     <= 1'b0;
            tick_prev_q    <= 1'b0;
            expire_pulse_q <= 1'b0;
            expired_flag_q <= 1'b0;
            overrun_flag_q <= 1'b0;
            start_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            reload_q       <= reload_d;
            periodic_q     <= periodic_d;
            tick_prev_q    <= tick_prev_d;
            expire_pulse_q <= expire_pulse_d;
            expired_flag_q <= expired_flag_d;
            overrun_flag_q <= overrun_flag_d;
            start_err_q    <= start_err_d;
        end
    end

    assign count_out    = count_q;
    assign expire_pulse = expire_pulse_q;
    assign expired_flag = expired_flag_q;
    assign overrun_flag = overrun_flag_q;
    assign start_err    = start_err_q;
    assign busy         = (state_q == ST_RUN);
    assign state_out    = state_q;

endmodule
`default_nettype wire
